// File: rtl/adc_dsp_csr_bank.sv
`default_nettype none
// ============================================================================
// Module      : adc_dsp_csr_bank
// Description : CSR bank for the ADC-chip DSP block: reset pulse, sticky
//               errors with mask/irq, channel select and banked NB/WB gains.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_dsp_csr_bank #(
    parameter logic [9:0] CHIP_PREFIX = 10'h223,
    parameter logic [3:0] MOD_PREFIX  = 4'h0,
    parameter int         NUM_CH      = 4,
    parameter int         GAIN_W      = 16,
    parameter int         NUM_ERR     = 8,
    parameter int         RST_CYCLES  = 16,
    localparam int        CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       i_sysclk,
    input  logic                       i_srst,
    input  logic                       i_cmd_valid,
    output logic                       o_cmd_ready,
    input  logic                       i_cmd_wr,
    input  logic [25:0]                i_cmd_addr,
    input  logic [31:0]                i_cmd_wdata,
    output logic                       o_rd_valid,
    output logic [31:0]                o_rd_data,
    output logic                       o_bad_addr,
    input  logic [NUM_ERR-1:0]         i_err_event,
    output logic                       o_err_irq,
    output logic                       o_dsp_reset,
    output logic [CH_W-1:0]            o_channel,
    output logic [NUM_CH*GAIN_W-1:0]   o_nb_gain,
    output logic [NUM_CH*GAIN_W-1:0]   o_wb_gain
);

    localparam int                CNT_W        = $clog2(RST_CYCLES + 1);
    localparam logic [CNT_W-1:0]  c_RST_LOAD   = CNT_W'(RST_CYCLES);
    localparam logic [GAIN_W-1:0] c_GAIN_UNITY = GAIN_W'(1) << (GAIN_W - 1);
    localparam logic [11:0]       c_OFF_RESET  = 12'h000;
    localparam logic [11:0]       c_OFF_ERROR  = 12'h004;
    localparam logic [11:0]       c_OFF_CHAN   = 12'h008;
    localparam logic [11:0]       c_OFF_NBGAIN = 12'h00C;
    localparam logic [11:0]       c_OFF_WBGAIN = 12'h010;
    localparam logic [11:0]       c_OFF_MASK   = 12'h014;
    localparam logic [31:0]       c_MISS_DATA  = 32'hDEAD_BEEF;

    logic                r_cmd_ready;
    logic                r_rd_valid;
    logic [31:0]         r_rd_data;
    logic                r_bad_addr;
    logic                r_in_rst;
    logic [CNT_W-1:0]    r_rst_cnt;
    logic [NUM_ERR-1:0]  r_err_sticky;
    logic [NUM_ERR-1:0]  r_err_mask;
    logic                r_err_irq;
    logic [CH_W-1:0]     r_channel;
    logic [GAIN_W-1:0]   r_nb_gain [NUM_CH];
    logic [GAIN_W-1:0]   r_wb_gain [NUM_CH];

    logic                w_accept;
    logic                w_wr;
    logic                w_rd;
    logic                w_prefix_ok;
    logic                w_sel_reset;
    logic                w_sel_error;
    logic                w_sel_chan;
    logic                w_sel_nb;
    logic                w_sel_wb;
    logic                w_sel_mask;
    logic                w_hit;
    logic                w_ch_ok;
    logic                w_dsp_reset;
    logic [NUM_ERR-1:0]  w_w1c;
    logic [31:0]         w_rdata;

    assign w_accept    = i_cmd_valid && r_cmd_ready;
    assign w_wr        = w_accept && i_cmd_wr;
    assign w_rd        = w_accept && !i_cmd_wr;
    assign w_prefix_ok = (i_cmd_addr[25:16] == CHIP_PREFIX) &&
                         (i_cmd_addr[15:12] == MOD_PREFIX) &&
                         (i_cmd_addr[1:0] == 2'b00);
    assign w_sel_reset = w_prefix_ok && (i_cmd_addr[11:0] == c_OFF_RESET);
    assign w_sel_error = w_prefix_ok && (i_cmd_addr[11:0] == c_OFF_ERROR);
    assign w_sel_chan  = w_prefix_ok && (i_cmd_addr[11:0] == c_OFF_CHAN);
    assign w_sel_nb    = w_prefix_ok && (i_cmd_addr[11:0] == c_OFF_NBGAIN);
    assign w_sel_wb    = w_prefix_ok && (i_cmd_addr[11:0] == c_OFF_WBGAIN);
    assign w_sel_mask  = w_prefix_ok && (i_cmd_addr[11:0] == c_OFF_MASK);
    assign w_hit       = w_sel_reset || w_sel_error || w_sel_chan ||
                         w_sel_nb || w_sel_wb || w_sel_mask;
    assign w_ch_ok     = (i_cmd_wdata < 32'(NUM_CH));
    assign w_w1c       = (w_wr && w_sel_error) ? i_cmd_wdata[NUM_ERR-1:0] : '0;
    // The pulse is held off while in reset so it starts on the first free cycle.
    assign w_dsp_reset = (r_rst_cnt != '0) && !r_in_rst;

    always_comb begin
        w_rdata = '0;
        if (!w_hit) begin
            w_rdata = c_MISS_DATA;
        end else if (w_sel_reset) begin
            w_rdata[0] = w_dsp_reset;
        end else if (w_sel_error) begin
            w_rdata[NUM_ERR-1:0] = r_err_sticky;
        end else if (w_sel_chan) begin
            w_rdata[CH_W-1:0] = r_channel;
        end else if (w_sel_nb) begin
            w_rdata[GAIN_W-1:0] = r_nb_gain[r_channel];
        end else if (w_sel_wb) begin
            w_rdata[GAIN_W-1:0] = r_wb_gain[r_channel];
        end else begin
            w_rdata[NUM_ERR-1:0] = r_err_mask;
        end
    end

    always_ff @(posedge i_sysclk) begin
        if (i_srst) begin
            r_cmd_ready  <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_data    <= '0;
            r_bad_addr   <= 1'b0;
            r_in_rst     <= 1'b1;
            r_rst_cnt    <= c_RST_LOAD;
            r_err_sticky <= '0;
            r_err_mask   <= '0;
            r_err_irq    <= 1'b0;
            r_channel    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_nb_gain[i] <= c_GAIN_UNITY;
                r_wb_gain[i] <= c_GAIN_UNITY;
            end
        end else begin
            r_in_rst    <= 1'b0;
            r_cmd_ready <= !w_rd;
            r_rd_valid  <= w_rd;
            if (w_rd) begin
                r_rd_data <= w_rdata;
            end
            r_bad_addr <= w_accept && (!w_hit || (i_cmd_wr && w_sel_chan && !w_ch_ok));

            if (w_wr && w_sel_reset && i_cmd_wdata[0]) begin
                r_rst_cnt <= c_RST_LOAD;
            end else if (!r_in_rst && (r_rst_cnt != '0)) begin
                r_rst_cnt <= r_rst_cnt - CNT_W'(1);
            end

            // New events win over a same-cycle clear.
            r_err_sticky <= (r_err_sticky & ~w_w1c) | i_err_event;
            r_err_irq    <= |(r_err_sticky & r_err_mask);
            if (w_wr && w_sel_mask) begin
                r_err_mask <= i_cmd_wdata[NUM_ERR-1:0];
            end
            if (w_wr && w_sel_chan && w_ch_ok) begin
                r_channel <= i_cmd_wdata[CH_W-1:0];
            end
            if (w_wr && w_sel_nb) begin
                r_nb_gain[r_channel] <= i_cmd_wdata[GAIN_W-1:0];
            end
            if (w_wr && w_sel_wb) begin
                r_wb_gain[r_channel] <= i_cmd_wdata[GAIN_W-1:0];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_gain_out
        assign o_nb_gain[g*GAIN_W +: GAIN_W] = r_nb_gain[g];
        assign o_wb_gain[g*GAIN_W +: GAIN_W] = r_wb_gain[g];
    end

    assign o_cmd_ready = r_cmd_ready;
    assign o_rd_valid  = r_rd_valid;
    assign o_rd_data   = r_rd_data;
    assign o_bad_addr  = r_bad_addr;
    assign o_err_irq   = r_err_irq;
    assign o_dsp_reset = w_dsp_reset;
    assign o_channel   = r_channel;

endmodule
`default_nettype wire

// File: tb/tb_adc_dsp_csr_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_dsp_csr_bank
// Description : Directed plus randomized bench for adc_dsp_csr_bank with a
//               cycle-level register-map reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_dsp_csr_bank;

    localparam int NUM_CH     = 4;
    localparam int GAIN_W     = 16;
    localparam int NUM_ERR    = 8;
    localparam int RST_CYCLES = 16;

    logic        clk = 1'b0;
    logic        srst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_wr = 1'b0;
    logic [25:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        bad_addr;
    logic [7:0]  err_event = '0;
    logic        err_irq;
    logic        dsp_reset;
    logic [1:0]  channel;
    logic [63:0] nb_gain;
    logic [63:0] wb_gain;

    always #5 clk = ~clk;

    adc_dsp_csr_bank #(
        .CHIP_PREFIX(10'h223), .MOD_PREFIX(4'h0), .NUM_CH(NUM_CH),
        .GAIN_W(GAIN_W), .NUM_ERR(NUM_ERR), .RST_CYCLES(RST_CYCLES)
    ) dut (
        .i_sysclk(clk), .i_srst(srst), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_wr(cmd_wr), .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata),
        .o_rd_valid(rd_valid), .o_rd_data(rd_data), .o_bad_addr(bad_addr),
        .i_err_event(err_event), .o_err_irq(err_irq), .o_dsp_reset(dsp_reset),
        .o_channel(channel), .o_nb_gain(nb_gain), .o_wb_gain(wb_gain)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state (values as seen after the most recent edge)
    int          cyc = 0;
    int          rst_until = -1;
    bit          m_in_rst = 1'b1;
    bit          m_ready = 1'b0;
    bit          m_rd_valid = 1'b0;
    logic [31:0] m_rd_data = '0;
    bit          m_bad = 1'b0;
    bit          m_irq = 1'b0;
    int          m_ch = 0;
    logic [15:0] m_nb [NUM_CH];
    logic [15:0] m_wb [NUM_CH];
    logic [7:0]  m_sticky = '0;
    logic [7:0]  m_mask = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Register index of an address, or -1 when the access misses the map.
    function automatic int decode(input logic [25:0] a);
        if (a[25:16] != 10'h223 || a[15:12] != 4'h0 || a[1:0] != 2'b00) return -1;
        case (a[11:0])
            12'h000: return 0;
            12'h004: return 1;
            12'h008: return 2;
            12'h00C: return 3;
            12'h010: return 4;
            12'h014: return 5;
            default: return -1;
        endcase
    endfunction

    function automatic bit dsp_now();
        return !m_in_rst && (cyc <= rst_until);
    endfunction

    function automatic logic [31:0] model_read(input int sel);
        case (sel)
            0:       return {31'b0, dsp_now()};
            1:       return {24'b0, m_sticky};
            2:       return 32'(m_ch);
            3:       return {16'b0, m_nb[m_ch]};
            4:       return {16'b0, m_wb[m_ch]};
            5:       return {24'b0, m_mask};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // One clock: predict from the driven inputs, advance, then compare everything.
    task automatic tick();
        bit          acc;
        bit          wr;
        bit          pre_irq;
        int          sel;
        logic [31:0] rdexp;
        logic [63:0] enb;
        logic [63:0] ewb;
        pre_irq = |(m_sticky & m_mask);
        acc     = cmd_valid && m_ready;
        wr      = cmd_wr;
        sel     = decode(cmd_addr);
        rdexp   = model_read(sel);
        @(posedge clk);
        #1;
        cyc++;
        if (srst) begin
            m_in_rst = 1'b1; m_ready = 1'b0; m_rd_valid = 1'b0; m_rd_data = '0;
            m_bad = 1'b0; m_irq = 1'b0; m_ch = 0; m_sticky = '0; m_mask = '0;
            rst_until = -1;
            for (int c = 0; c < NUM_CH; c++) begin
                m_nb[c] = 16'h8000;
                m_wb[c] = 16'h8000;
            end
        end else begin
            if (m_in_rst) begin
                m_in_rst  = 1'b0;
                rst_until = cyc + RST_CYCLES - 1;
            end
            m_bad = acc && (sel < 0 || (wr && sel == 2 && cmd_wdata >= 32'(NUM_CH)));
            m_sticky = (m_sticky & ~((acc && wr && sel == 1) ? cmd_wdata[7:0] : 8'h00)) | err_event;
            if (acc && wr) begin
                case (sel)
                    0: if (cmd_wdata[0]) rst_until = cyc + RST_CYCLES - 1;
                    2: if (cmd_wdata < 32'(NUM_CH)) m_ch = int'(cmd_wdata);
                    3: m_nb[m_ch] = cmd_wdata[15:0];
                    4: m_wb[m_ch] = cmd_wdata[15:0];
                    5: m_mask = cmd_wdata[7:0];
                    default: ;
                endcase
            end
            m_rd_valid = acc && !wr;
            if (m_rd_valid) m_rd_data = rdexp;
            m_ready = !(acc && !wr);
            m_irq   = pre_irq;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            enb[c*16 +: 16] = m_nb[c];
            ewb[c*16 +: 16] = m_wb[c];
        end
        chk("cmd_ready", 64'(cmd_ready), 64'(m_ready));
        chk("rd_valid", 64'(rd_valid), 64'(m_rd_valid));
        chk("rd_data", 64'(rd_data), 64'(m_rd_data));
        chk("bad_addr", 64'(bad_addr), 64'(m_bad));
        chk("err_irq", 64'(err_irq), 64'(m_irq));
        chk("dsp_reset", 64'(dsp_reset), 64'(dsp_now()));
        chk("channel", 64'(channel), 64'(m_ch));
        chk("nb_gain", nb_gain, enb);
        chk("wb_gain", wb_gain, ewb);
    endtask

    task automatic do_cmd(input bit wr, input logic [25:0] addr, input logic [31:0] wd,
                          input logic [7:0] ev);
        int guard = 0;
        while (!m_ready && guard < 10) begin
            tick();
            guard++;
        end
        cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wd; err_event = ev;
        tick();
        cmd_valid = 1'b0; cmd_wr = 1'b0; err_event = '0;
    endtask

    task automatic rd(input logic [25:0] addr, output logic [31:0] data);
        do_cmd(1'b0, addr, 32'h0, 8'h00);
        data = rd_data;
    endtask

    function automatic logic [25:0] reg_addr(input logic [11:0] off);
        return {10'h223, 4'h0, off};
    endfunction

    initial begin
        logic [31:0] d;
        int          hi;
        int          k;
        logic [11:0] off;
        logic [25:0] a;
        logic [31:0] wd;

        // Reset and the power-on DSP reset pulse
        repeat (3) tick();
        srst = 1'b0;
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (dsp_reset) hi++;
        end
        chk("rst_pulse_len", 64'(hi), 64'd16);

        rd(reg_addr(12'h008), d);
        chk("chan_reset", 64'(d), 64'h0);
        rd(reg_addr(12'h00C), d);
        chk("nbgain_reset", 64'(d), 64'h8000);

        // Banked gain access
        do_cmd(1'b1, reg_addr(12'h008), 32'd2, 8'h00);
        do_cmd(1'b1, reg_addr(12'h010), 32'h1234, 8'h00);
        do_cmd(1'b1, reg_addr(12'h008), 32'd0, 8'h00);
        rd(reg_addr(12'h010), d);
        chk("wbgain_ch0", 64'(d), 64'h8000);
        chk("wbgain_ch2_port", 64'(wb_gain[47:32]), 64'h1234);

        // Sticky errors, mask, irq, W1C
        err_event = 8'h05;
        tick();
        err_event = 8'h00;
        rd(reg_addr(12'h004), d);
        chk("err_sticky", 64'(d), 64'h05);
        do_cmd(1'b1, reg_addr(12'h014), 32'h04, 8'h00);
        tick();
        tick();
        chk("irq_set", 64'(err_irq), 64'h1);
        do_cmd(1'b1, reg_addr(12'h004), 32'h04, 8'h00);
        tick();
        tick();
        chk("irq_clear", 64'(err_irq), 64'h0);
        rd(reg_addr(12'h004), d);
        chk("err_w1c", 64'(d), 64'h01);
        do_cmd(1'b1, reg_addr(12'h004), 32'h01, 8'h01);
        rd(reg_addr(12'h004), d);
        chk("err_set_wins", 64'(d), 64'h01);

        // Illegal channel and address misses
        do_cmd(1'b1, reg_addr(12'h008), 32'd7, 8'h00);
        chk("bad_chan_pulse", 64'(bad_addr), 64'h1);
        chk("bad_chan_keep", 64'(channel), 64'h0);
        rd(26'h2240008, d);
        chk("miss_data", 64'(d), 64'hDEAD_BEEF);
        chk("miss_pulse", 64'(bad_addr), 64'h1);

        // Restarted DSP reset pulse: writes at cycle 0 and cycle 10
        hi = 0;
        do_cmd(1'b1, reg_addr(12'h000), 32'h1, 8'h00);
        if (dsp_reset) hi++;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (dsp_reset) hi++;
        end
        do_cmd(1'b1, reg_addr(12'h000), 32'h1, 8'h00);
        if (dsp_reset) hi++;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (dsp_reset) hi++;
        end
        chk("rst_restart_len", 64'(hi), 64'd26);

        // Back-to-back reads
        rd(reg_addr(12'h008), d);
        chk("b2b_rd0", 64'(d), 64'h0);
        rd(reg_addr(12'h00C), d);
        chk("b2b_rd1", 64'(d), 64'h8000);

        // Reset arriving with a read: response dropped, ready returns after reset
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = reg_addr(12'h008); srst = 1'b1;
        tick();
        cmd_valid = 1'b0; srst = 1'b0;
        tick();
        chk("ready_after_rst", 64'(cmd_ready), 64'h1);
        repeat (18) tick();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            k   = int'($urandom_range(0, 11));
            off = 12'(4 * $urandom_range(0, 5));
            a   = reg_addr(off);
            if (k == 0) a = 26'($urandom);
            else if (k == 1) a = reg_addr(12'h018);
            else if (k == 2) a = reg_addr(off | 12'h002);
            wd = $urandom;
            if (off == 12'h008) wd = 32'($urandom_range(0, 5));
            if (off == 12'h000 && $urandom_range(0, 3) != 0) wd = 32'h0;
            do_cmd(1'($urandom_range(0, 1)), a, wd,
                   ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00);
            if ($urandom_range(0, 3) == 0) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
